// File: rtl/nand_op_scheduler.sv
// Round-robin arbiter sharing one combinational WIDTH-bit NAND unit between N_REQ requesters.
// Accept in IDLE, drive the NAND unit in EXEC, hold the tagged result in RESP until consumed.
module nand_op_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]       nand_a,
    output logic [WIDTH-1:0]       nand_b,
    input  logic [WIDTH-1:0]       nand_y,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy,
    output logic [15:0]            ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   cur_id;
    logic [WIDTH-1:0]  op_a, op_b;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic [WIDTH-1:0]  sel_a, sel_b;

    // Search starts just after the last winner and wraps modulo N_REQ, not 2**ID_W.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_vld && (i == idx) && req_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_id  = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        nand_a    = '0;
        nand_b    = '0;
        res_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = EXEC;
                    for (int i = 0; i < N_REQ; i++) begin
                        req_ready[i] = (grant_id == ID_W'(i));
                    end
                end
            end
            EXEC: begin
                nand_a    = op_a;
                nand_b    = op_b;
                state_nxt = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= ID_W'(N_REQ - 1);
            cur_id   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            res_data <= '0;
            res_id   <= '0;
            ops_done <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        cur_id <= grant_id;
                    end
                end
                EXEC: begin
                    res_data <= nand_y;
                    res_id   <= cur_id;
                end
                RESP: begin
                    if (res_ready) begin
                        rr_ptr <= cur_id;
                        if (ops_done != 16'hFFFF) ops_done <= ops_done + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_op_scheduler.sv
// Bench for nand_op_scheduler: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized requester/consumer phase.
module tb_nand_op_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   nand_a, nand_b, nand_y;
    logic           res_valid, res_ready;
    logic [W-1:0]   res_data;
    logic [IW-1:0]  res_id;
    logic           busy;
    logic [15:0]    ops_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    nand_op_scheduler #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .nand_a(nand_a), .nand_b(nand_b), .nand_y(nand_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id),
        .busy(busy), .ops_done(ops_done)
    );

    assign nand_y = ~(nand_a & nand_b);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Reference model: one outstanding transaction, its age in cycles since acceptance.
    bit          m_has;
    int          m_age;
    int          m_last;
    int          m_id;
    logic [W-1:0] m_a, m_b;
    logic [W-1:0] m_res_data;
    int          m_res_id;
    logic [15:0] m_cnt;

    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_has = 0; m_age = 0; m_last = N - 1; m_id = 0;
            m_a = '0; m_b = '0; m_res_data = '0; m_res_id = 0; m_cnt = '0;
        end else if (!m_has) begin
            g = rr_pick(req_valid, m_last);
            if (g >= 0) begin
                m_has = 1; m_age = 0; m_id = g;
                m_a = req_a[g*W +: W];
                m_b = req_b[g*W +: W];
            end
        end else if (m_age == 0) begin
            m_age = 1;
            m_res_data = ~(m_a & m_b);
            m_res_id = m_id;
        end else if (res_ready) begin
            m_last = m_id;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_has = 0;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        int g;
        if (chk_en) begin
            e_ready = '0;
            if (!m_has) begin
                g = rr_pick(req_valid, m_last);
                if (g >= 0) e_ready[g] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("nand_a", 32'(nand_a), (m_has && m_age == 0) ? 32'(m_a) : 32'd0);
            chk("nand_b", 32'(nand_b), (m_has && m_age == 0) ? 32'(m_b) : 32'd0);
            chk("res_valid", 32'(res_valid), 32'(m_has && m_age >= 1));
            chk("res_data", 32'(res_data), 32'(m_res_data));
            chk("res_id", 32'(res_id), 32'(m_res_id));
            chk("busy", 32'(busy), 32'(m_has));
            chk("ops_done", 32'(ops_done), 32'(m_cnt));
        end
    end

    int           gq[$];
    int           gc[$];
    logic [N-1:0] last_ready = '0;

    always @(negedge clk) begin
        last_ready = req_ready;
        if (chk_en && req_ready != '0) begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    gq.push_back(i);
                    gc.push_back(cyc);
                end
            end
        end
    end

    // Advance to just after the next rising edge; an accepted requester drops its valid.
    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~last_ready;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int budget;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        repeat (5) step();
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle ops_done", 32'(ops_done), 32'd0);
        chk("idle res_valid", 32'(res_valid), 32'd0);
        chk("idle res_data", 32'(res_data), 32'd0);

        // First transaction: F0 NAND 3C
        step();
        set_ops(0, 8'hF0, 8'h3C);
        req_valid = 4'b0001;
        res_ready = 1'b1;
        @(negedge clk);
        chk("t1 ready@T", 32'(req_ready), 32'h1);
        step();
        @(negedge clk);
        chk("t1 res_valid@T+1", 32'(res_valid), 32'd0);
        step();
        @(negedge clk);
        chk("t1 res_valid@T+2", 32'(res_valid), 32'd1);
        chk("t1 res_data", 32'(res_data), 32'hCF);
        chk("t1 res_id", 32'(res_id), 32'd0);
        step();
        @(negedge clk);
        chk("t1 ops_done", 32'(ops_done), 32'd1);
        chk("t1 busy", 32'(busy), 32'd0);

        // All requesters continuously valid from reset
        step();
        do_reset();
        gq.delete(); gc.delete();
        for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom));
        req_valid = 4'b1111;
        budget = 0;
        while (gq.size() < 5 && budget < 40) begin
            step();
            budget++;
            if (gq.size() < 5) req_valid = 4'b1111;
        end
        req_valid = 4'b0101;
        chk("rr count", 32'(gq.size()), 32'd5);
        if (gq.size() >= 5) begin
            chk("rr g0", 32'(gq[0]), 32'd0);
            chk("rr g1", 32'(gq[1]), 32'd1);
            chk("rr g2", 32'(gq[2]), 32'd2);
            chk("rr g3", 32'(gq[3]), 32'd3);
            chk("rr g4", 32'(gq[4]), 32'd0);
            for (int k = 1; k < 5; k++) chk("rr spacing", 32'(gc[k] - gc[k-1]), 32'd3);
        end

        // Two requesters held: 2 was granted last round, expect 2,0,2 from last winner 0
        gq.delete(); gc.delete();
        budget = 0;
        while (gq.size() < 3 && budget < 40) begin
            step();
            budget++;
            if (gq.size() < 3) req_valid = 4'b0101;
        end
        req_valid = '0;
        chk("pair count", 32'(gq.size()), 32'd3);
        if (gq.size() >= 3) begin
            chk("pair g0", 32'(gq[0]), 32'd2);
            chk("pair g1", 32'(gq[1]), 32'd0);
            chk("pair g2", 32'(gq[2]), 32'd2);
        end
        repeat (4) step();

        // Backpressure in RESP with FF NAND FF
        gq.delete(); gc.delete();
        res_ready = 1'b0;
        set_ops(1, 8'hFF, 8'hFF);
        req_valid = 4'b0010;
        budget = 0;
        while (gq.size() < 1 && budget < 10) begin
            step();
            budget++;
        end
        chk("bp accept", 32'(gq.size()), 32'd1);
        req_valid = 4'b1101;
        step();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp res_valid", 32'(res_valid), 32'd1);
            chk("bp res_data", 32'(res_data), 32'h00);
            chk("bp req_ready", 32'(req_ready), 32'd0);
            step();
        end
        res_ready = 1'b1;
        req_valid = '0;
        step();
        @(negedge clk);
        chk("bp released busy", 32'(busy), 32'd0);

        // Reset while in EXEC discards the operation and restores priority to requester 0
        step();
        set_ops(2, 8'h12, 8'h34);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("rx ready", 32'(req_ready), 32'h4);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rx in EXEC", 32'(nand_a), 32'h12);
        step();
        rst = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rx res_valid", 32'(res_valid), 32'd0);
        chk("rx grant0", 32'(req_ready), 32'h1);
        req_valid = '0;
        repeat (6) step();

        // Randomized requesters and consumer
        for (int t = 0; t < 400; t++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 3 == 0)) begin
                    set_ops(i, W'($urandom), W'($urandom));
                    req_valid[i] = 1'b1;
                end
            end
            res_ready = ($urandom % 4) != 0;
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (6) step();

        // Counter saturation from a preloaded value
        force dut.ops_done = 16'hFFFE;
        m_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.ops_done;
        for (int t = 0; t < 12; t++) begin
            step();
            req_valid[0] = 1'b1;
            set_ops(0, W'($urandom), W'($urandom));
        end
        req_valid = '0;
        repeat (4) step();
        @(negedge clk);
        chk("sat ops_done", 32'(ops_done), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
